// File: rtl/pixel_write_sink.sv
// Pixel-write sink: buffers drawer pixel writes in a FIFO and drains them into the
// VGA framebuffer write port one per cycle, reporting drain completion to control.
module pixel_write_sink #(
  parameter int DEPTH    = 8,
  parameter int COLOUR_W = 3,
  parameter int Y_MAX    = 176
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          pix_x,
  input  logic [6:0]          pix_y,
  input  logic [COLOUR_W-1:0] pix_colour,
  input  logic                pix_write,
  output logic                pix_ready,
  input  logic                done_in,
  output logic                done_out,
  input  logic                fb_stall,
  output logic [14:0]         fb_addr,
  output logic [COLOUR_W-1:0] fb_colour,
  output logic                fb_we,
  output logic                overflow,
  input  logic                count_clear,
  output logic [15:0]         pix_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 15 + COLOUR_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  Y_LIM    = 8'(Y_MAX);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [14:0]         fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0] fb_colour_q, fb_colour_d;
  logic                fb_we_q, fb_we_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         pix_count_q, pix_count_d;
  state_t              state_q, state_d;
  logic                done_out_q, done_out_d;

  logic                pix_ready_s;
  logic                in_range_s;
  logic                push_s;
  logic                pop_s;
  logic                drained_s;
  logic [EW-1:0]       entry_s;
  logic [EW-1:0]       head_s;

  // Handshake decode; out-of-range rows are accepted but never stored.
  always_comb begin
    pix_ready_s = (cnt_q != FULL_CNT);
    in_range_s  = ({1'b0, pix_y} < Y_LIM);
    push_s      = pix_write && pix_ready_s && in_range_s;
    pop_s       = (cnt_q != {(AW+1){1'b0}}) && !fb_stall;
    drained_s   = (cnt_q == {(AW+1){1'b0}}) && !pop_s && !push_s;
    entry_s     = {pix_y, pix_x, pix_colour};
    head_s      = mem_q[rd_ptr_q];
  end

  // FIFO pointers, occupancy and framebuffer write-port next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    fb_addr_d   = fb_addr_q;
    fb_colour_d = fb_colour_q;
    fb_we_d     = pop_s;
    overflow_d  = overflow_q || (pix_write && !pix_ready_s);
    pix_count_d = pix_count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      fb_addr_d   = head_s[EW-1:COLOUR_W];
      fb_colour_d = head_s[COLOUR_W-1:0];
    end else begin
      rd_ptr_d    = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    // Clear takes priority over a same-edge increment.
    if (count_clear) begin
      pix_count_d = 16'd0;
    end else if (pop_s) begin
      pix_count_d = pix_count_q + 16'd1;
    end else begin
      pix_count_d = pix_count_q;
    end
  end

  // Done FSM next state: WAIT persists until the FIFO is empty with no traffic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (done_in) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (drained_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Done FSM output: single pulse on the WAIT exit edge.
  always_comb begin
    done_out_d = 1'b0;
    if (state_q == S_WAIT) begin
      done_out_d = drained_s;
    end else begin
      done_out_d = 1'b0;
    end
  end

  // Done FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_out_q <= done_out_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Pointer, occupancy and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      cnt_q       <= {(AW+1){1'b0}};
      fb_addr_q   <= 15'd0;
      fb_colour_q <= {COLOUR_W{1'b0}};
      fb_we_q     <= 1'b0;
      overflow_q  <= 1'b0;
      pix_count_q <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      fb_addr_q   <= fb_addr_d;
      fb_colour_q <= fb_colour_d;
      fb_we_q     <= fb_we_d;
      overflow_q  <= overflow_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign pix_ready = pix_ready_s;
  assign done_out  = done_out_q;
  assign fb_addr   = fb_addr_q;
  assign fb_colour = fb_colour_q;
  assign fb_we     = fb_we_q;
  assign overflow  = overflow_q;
  assign pix_count = pix_count_q;

endmodule
